// File: rtl/urv_divide_iter_if.sv
// Execute-stage handshake and operand bus between pipeline control and the divide unit.
// Member names are kept as seen from the divider, so _i means "into the divider".
interface urv_divide_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             x_stall_i;
  logic             x_kill_i;
  logic             x_stall_req_o;
  logic             d_valid_i;
  logic             d_is_divide_i;
  logic [2:0]       d_fun_i;
  logic [WIDTH-1:0] d_rs1_i;
  logic [WIDTH-1:0] d_rs2_i;
  logic [WIDTH-1:0] x_rd_o;

  modport slave (
    input  x_stall_i, x_kill_i, d_valid_i, d_is_divide_i, d_fun_i, d_rs1_i, d_rs2_i,
    output x_stall_req_o, x_rd_o
  );

  modport master (
    output x_stall_i, x_kill_i, d_valid_i, d_is_divide_i, d_fun_i, d_rs1_i, d_rs2_i,
    input  x_stall_req_o, x_rd_o
  );
endinterface

// File: rtl/urv_divide_iter.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit: restoring shift-subtract on operand magnitudes,
// BITS_PER_CYCLE quotient bits per clock, sign fix-up applied in a final cycle.
module urv_divide_iter #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned EARLY_OUT      = 1
) (
  input logic              clk_i,
  input logic              rst_i,
  urv_divide_iter_if.slave bus
);

  localparam int unsigned ITERS = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(ITERS + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic             rem_sel_q, rem_sel_d;

  logic             start;
  logic             is_signed;
  logic             rs1_neg, rs2_neg;
  logic             div_zero, overflow;
  logic [WIDTH-1:0] abs_rs1, abs_rs2;
  logic [WIDTH-1:0] step_quot, step_rem;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] fix_sel, fix_val;
  logic             unused_fun;

  assign unused_fun = bus.d_fun_i[2];

  assign start = bus.d_valid_i & bus.d_is_divide_i & ~bus.x_kill_i & (state_q == IDLE);

  // Operand decode: magnitudes and the two RISC-V special cases
  always_comb begin
    is_signed = ~bus.d_fun_i[0];
    rs1_neg   = is_signed & bus.d_rs1_i[WIDTH-1];
    rs2_neg   = is_signed & bus.d_rs2_i[WIDTH-1];
    abs_rs1   = rs1_neg ? (~bus.d_rs1_i + WIDTH'(1)) : bus.d_rs1_i;
    abs_rs2   = rs2_neg ? (~bus.d_rs2_i + WIDTH'(1)) : bus.d_rs2_i;
    div_zero  = (bus.d_rs2_i == '0);
    overflow  = is_signed & (bus.d_rs1_i == MOST_NEG) & (&bus.d_rs2_i);
  end

  // BITS_PER_CYCLE restoring stages; trial is the WIDTH+1 bit partial remainder
  always_comb begin
    step_quot = quot_q;
    step_rem  = rem_q;
    trial     = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      trial = {step_rem, step_quot[WIDTH-1]};
      if (trial >= {1'b0, dvsr_q}) begin
        step_rem  = WIDTH'(trial - {1'b0, dvsr_q});
        step_quot = {step_quot[WIDTH-2:0], 1'b1};
      end else begin
        step_rem  = trial[WIDTH-1:0];
        step_quot = {step_quot[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    fix_sel = rem_sel_q ? rem_q : quot_q;
    fix_val = (rem_sel_q ? neg_rem_q : neg_quot_q) ? (~fix_sel + WIDTH'(1)) : fix_sel;
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dvsr_d     = dvsr_q;
    rd_d       = rd_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    rem_sel_d  = rem_sel_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dvsr_d     = abs_rs2;
          quot_d     = abs_rs1;
          rem_d      = '0;
          neg_quot_d = rs1_neg ^ rs2_neg;
          neg_rem_d  = rs1_neg;
          rem_sel_d  = bus.d_fun_i[1];
          if (div_zero) begin
            rd_d    = bus.d_fun_i[1] ? bus.d_rs1_i : '1;
            state_d = DONE;
          end else if (overflow) begin
            rd_d    = bus.d_fun_i[1] ? '0 : bus.d_rs1_i;
            state_d = DONE;
          end else if ((EARLY_OUT != 0) && (abs_rs1 < abs_rs2)) begin
            quot_d  = '0;
            rem_d   = abs_rs1;
            state_d = FIX;
          end else begin
            cnt_d   = CNT_W'(ITERS);
            state_d = ITER;
          end
        end
      end
      ITER: begin
        if (bus.x_kill_i) begin
          state_d = IDLE;
        end else begin
          quot_d = step_quot;
          rem_d  = step_rem;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = FIX;
        end
      end
      FIX: begin
        if (bus.x_kill_i) begin
          state_d = IDLE;
        end else begin
          rd_d    = fix_val;
          state_d = DONE;
        end
      end
      DONE: begin
        // Another stall source may hold the pipeline; keep the result until it lets go
        if (bus.x_kill_i || !bus.x_stall_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      rd_q       <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      rem_sel_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dvsr_q     <= dvsr_d;
      rd_q       <= rd_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      rem_sel_q  <= rem_sel_d;
    end
  end

  assign bus.x_stall_req_o = (start | (state_q == ITER) | (state_q == FIX)) & ~bus.x_kill_i;
  assign bus.x_rd_o        = rd_q;

endmodule

// File: tb/tb_urv_divide_iter.sv
// Scoreboard bench driving three divider configurations in lock-step from a shared pipeline model.
module tb_urv_divide_iter;

  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;

  typedef struct {
    logic [31:0] res;
    logic [31:0] lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, is_div, kill, ext_stall;
  logic [2:0]  fun;
  logic [31:0] rs1, rs2;
  logic        any_req;

  int checks = 0;
  int errors = 0;

  exp_t sb1[$];
  exp_t sb4[$];
  exp_t sb2[$];
  logic [31:0] last1, last4, last2;

  always #5 clk = ~clk;

  urv_divide_iter_if #(.WIDTH(32)) if1 ();
  urv_divide_iter_if #(.WIDTH(32)) if4 ();
  urv_divide_iter_if #(.WIDTH(32)) if2 ();

  urv_divide_iter #(.WIDTH(32), .BITS_PER_CYCLE(1), .EARLY_OUT(1)) u_d1 (
    .clk_i(clk), .rst_i(rst), .bus(if1.slave));
  urv_divide_iter #(.WIDTH(32), .BITS_PER_CYCLE(4), .EARLY_OUT(1)) u_d4 (
    .clk_i(clk), .rst_i(rst), .bus(if4.slave));
  urv_divide_iter #(.WIDTH(32), .BITS_PER_CYCLE(2), .EARLY_OUT(0)) u_d2 (
    .clk_i(clk), .rst_i(rst), .bus(if2.slave));

  // Global stall: any unit still busy, plus an external stall source
  assign any_req = if1.x_stall_req_o | if4.x_stall_req_o | if2.x_stall_req_o;

  assign if1.x_stall_i = any_req | ext_stall;
  assign if1.x_kill_i = kill;
  assign if1.d_valid_i = valid;
  assign if1.d_is_divide_i = is_div;
  assign if1.d_fun_i = fun;
  assign if1.d_rs1_i = rs1;
  assign if1.d_rs2_i = rs2;

  assign if4.x_stall_i = any_req | ext_stall;
  assign if4.x_kill_i = kill;
  assign if4.d_valid_i = valid;
  assign if4.d_is_divide_i = is_div;
  assign if4.d_fun_i = fun;
  assign if4.d_rs1_i = rs1;
  assign if4.d_rs2_i = rs2;

  assign if2.x_stall_i = any_req | ext_stall;
  assign if2.x_kill_i = kill;
  assign if2.d_valid_i = valid;
  assign if2.d_is_divide_i = is_div;
  assign if2.d_fun_i = fun;
  assign if2.d_rs1_i = rs1;
  assign if2.d_rs2_i = rs2;

  function automatic exp_t model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input int unsigned bpc, input bit eo);
    exp_t e;
    logic sgn, rsel;
    logic [31:0] ma, mb;
    sgn = ~f[0];
    rsel = f[1];
    ma = (sgn && a[31]) ? 32'(-a) : a;
    mb = (sgn && b[31]) ? 32'(-b) : b;
    if (b == 32'h0) begin
      e.res = rsel ? a : 32'hFFFF_FFFF;
      e.lat = 1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.res = rsel ? 32'h0 : a;
      e.lat = 1;
    end else begin
      if (sgn) e.res = rsel ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
      else     e.res = rsel ? (a % b) : (a / b);
      e.lat = (eo && ma < mb) ? 32'd2 : 32'(32 / bpc + 2);
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " d1 req"}, 32'(if1.x_stall_req_o), 32'd0);
    check({tag, " d4 req"}, 32'(if4.x_stall_req_o), 32'd0);
    check({tag, " d2 req"}, 32'(if2.x_stall_req_o), 32'd0);
    check({tag, " d1 rd"}, if1.x_rd_o, last1);
    check({tag, " d4 rd"}, if4.x_rd_o, last4);
    check({tag, " d2 rd"}, if2.x_rd_o, last2);
  endtask

  // Called just after a rising edge with all units idle; returns the same way.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit hold);
    exp_t e;
    int unsigned n1, n4, n2;
    bit done;
    string tag;
    tag = $sformatf("f%0d %h/%h", f, a, b);
    sb1.push_back(model(f, a, b, 1, 1'b1));
    sb4.push_back(model(f, a, b, 4, 1'b1));
    sb2.push_back(model(f, a, b, 2, 1'b0));
    valid = 1'b1; fun = f; rs1 = a; rs2 = b;
    n1 = 0; n4 = 0; n2 = 0; done = 1'b0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      @(negedge clk);
      if (if1.x_stall_req_o) n1++;
      if (if4.x_stall_req_o) n4++;
      if (if2.x_stall_req_o) n2++;
      if (!any_req) done = 1'b1;
      else begin
        @(posedge clk); #1;
        // Operands are sampled only at start
        rs1 = $urandom; rs2 = $urandom;
      end
    end
    check({tag, " completion"}, 32'(done), 32'd1);
    e = sb1.pop_front(); last1 = e.res;
    check({tag, " d1 res"}, if1.x_rd_o, e.res);
    check({tag, " d1 lat"}, n1, e.lat);
    e = sb4.pop_front(); last4 = e.res;
    check({tag, " d4 res"}, if4.x_rd_o, e.res);
    check({tag, " d4 lat"}, n4, e.lat);
    e = sb2.pop_front(); last2 = e.res;
    check({tag, " d2 res"}, if2.x_rd_o, e.res);
    check({tag, " d2 lat"}, n2, e.lat);
    if (hold) begin
      ext_stall = 1'b1;
      repeat (3) begin
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs({tag, " hold"});
      end
      ext_stall = 1'b0;
    end
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; is_div = 1'b1; kill = 1'b0; ext_stall = 1'b0;
    fun = 3'b0; rs1 = 32'h0; rs2 = 32'h0;
    last1 = 32'h0; last4 = 32'h0; last2 = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    do_op(F_DIVU, 32'd100, 32'd7, 1'b0);
    do_op(F_REMU, 32'd100, 32'd7, 1'b0);
    do_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(F_REM, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(F_DIVU, 32'd5, 32'd0, 1'b0);
    do_op(F_REMU, 32'd5, 32'd0, 1'b0);
    do_op(F_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0);
    do_op(F_DIVU, 32'd3, 32'd10, 1'b0);
    do_op(F_REM, 32'hFFFF_FFFD, 32'd10, 1'b0);
    do_op(F_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
    do_op(F_REM, 32'd7, 32'hFFFF_FFFE, 1'b0);
    do_op(F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(F_REMU, 32'hFFFF_FFFF, 32'h0001_0003, 1'b0);
    do_op(F_DIVU, 32'hFFFF_FFFF, 32'h0001_0000, 1'b1);

    // Kill on the fifth iteration cycle
    valid = 1'b1; fun = F_DIVU; rs1 = 32'd1000; rs2 = 32'd3;
    repeat (5) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(negedge clk);
    check_idle_outputs("kill iter");
    @(posedge clk); #1;
    kill = 1'b0; valid = 1'b0;
    @(negedge clk);
    check_idle_outputs("after kill");
    @(posedge clk); #1;
    do_op(F_DIVU, 32'd9, 32'd3, 1'b0);

    // Kill on the start cycle, and a valid non-divide instruction
    valid = 1'b1; kill = 1'b1; fun = F_DIVU; rs1 = 32'd50; rs2 = 32'd5;
    @(negedge clk);
    check_idle_outputs("kill start");
    @(posedge clk); #1;
    kill = 1'b0; is_div = 1'b0;
    @(negedge clk);
    check_idle_outputs("not divide");
    @(posedge clk); #1;
    valid = 1'b0; is_div = 1'b1;
    @(negedge clk);
    check_idle_outputs("after kill start");
    @(posedge clk); #1;

    // Reset in the middle of iteration
    valid = 1'b1; fun = F_DIVU; rs1 = 32'd1000; rs2 = 32'd3;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1; valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    last1 = 32'h0; last4 = 32'h0; last2 = 32'h0;
    @(negedge clk);
    check_idle_outputs("reset mid iter");
    @(posedge clk); #1;
    do_op(F_REMU, 32'd1000, 32'd7, 1'b0);
    do_op(F_DIV, 32'h8000_0000, 32'd3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
